// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : instr_fetch_unit
//  Description : Instruction-fetch front end for the Control_unit decoder.
//                Holds the PC, fetches one 32-bit word per instruction over a
//                req/ack handshake with instruction memory, presents the held
//                instruction (plus opcode/funct3) until pc_en_i, then moves to
//                PC+4 or to the branch/jump target chosen by pcsrc_i.
//  Config      : FETCH_MISALIGN_TRAP_EN
//                  defined   - a misaligned next PC traps into FAULT
//                  undefined - next PC low two bits are forced to zero
//  Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch_unit #(
   parameter int unsigned     XLEN      = 32,
   parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
   parameter logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            pc_en_i,
   input  logic            pcsrc_i,
   input  logic [XLEN-1:0] target_addr_i,
   output logic            imem_req_o,
   output logic [XLEN-1:0] imem_addr_o,
   input  logic            imem_ack_i,
   input  logic [XLEN-1:0] imem_rdata_i,
   output logic [XLEN-1:0] instr_o,
   output logic            instr_valid_o,
   output logic [6:0]      opcode_o,
   output logic [2:0]      funct3_o,
   output logic [XLEN-1:0] pc_o,
   output logic [XLEN-1:0] pc_plus4_o,
   output logic [31:0]     fetch_count_o,
   output logic            fetch_fault_o
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_REQ   = 2'd1,
      S_HOLD  = 2'd2,
      S_FAULT = 2'd3
   } state_t;

   localparam logic [XLEN-1:0] c_PC_STEP  = {{(XLEN-3){1'b0}}, 3'b100};
   localparam logic [XLEN-1:0] c_ALIGN_MASK = ~{{(XLEN-2){1'b0}}, 2'b11};

   state_t            state_q, state_d;
   logic [XLEN-1:0]   pc_q, pc_d;
   logic [XLEN-1:0]   instr_q, instr_d;
   logic              instr_valid_q, instr_valid_d;
   logic              req_q, req_d;
   logic [31:0]       fetch_count_q, fetch_count_d;

   logic [XLEN-1:0]   pc_plus4_w;
   logic [XLEN-1:0]   next_pc_raw_w;
   logic [XLEN-1:0]   next_pc_w;
   logic              ack_accept_w;

   // Sequential PC arithmetic wraps naturally modulo 2^XLEN.
   assign pc_plus4_w    = pc_q + c_PC_STEP;
   assign next_pc_raw_w = pcsrc_i ? target_addr_i : pc_plus4_w;

   // An ack only counts while a request is actually outstanding, so acks
   // left over from before a reset (or arriving in IDLE) are dropped.
   assign ack_accept_w  = req_q & imem_ack_i;

`ifdef FETCH_MISALIGN_TRAP_EN
   logic fault_q, fault_d;
   logic misaligned_w;

   // The raw target is kept so a trapped PC shows the offending address.
   assign next_pc_w     = next_pc_raw_w;
   assign misaligned_w  = |next_pc_raw_w[1:0];
   assign fetch_fault_o = fault_q;
`else
   // Without the trap the PC is always word aligned.
   assign next_pc_w     = next_pc_raw_w & c_ALIGN_MASK;
   assign fetch_fault_o = 1'b0;
`endif

   // State and datapath registers; rst overrides every other input.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= S_IDLE;
         pc_q          <= RESET_PC;
         instr_q       <= NOP_INSTR;
         instr_valid_q <= 1'b0;
         req_q         <= 1'b0;
         fetch_count_q <= 32'd0;
`ifdef FETCH_MISALIGN_TRAP_EN
         fault_q       <= 1'b0;
`endif
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         instr_q       <= instr_d;
         instr_valid_q <= instr_valid_d;
         req_q         <= req_d;
         fetch_count_q <= fetch_count_d;
`ifdef FETCH_MISALIGN_TRAP_EN
         fault_q       <= fault_d;
`endif
      end
   end

   // Next-state and next-datapath decode for the fetch sequencer.
   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      instr_d       = instr_q;
      instr_valid_d = instr_valid_q;
      req_d         = req_q;
      fetch_count_d = fetch_count_q;
`ifdef FETCH_MISALIGN_TRAP_EN
      fault_d       = fault_q;
`endif

      case (state_q)
         // One dead cycle after reset, then start fetching at RESET_PC.
         S_IDLE: begin
            state_d = S_REQ;
            req_d   = 1'b1;
         end

         // Request and address stay put until memory answers.
         S_REQ: begin
            if (ack_accept_w) begin
               instr_d       = imem_rdata_i;
               instr_valid_d = 1'b1;
               req_d         = 1'b0;
               fetch_count_d = fetch_count_q + 32'd1;
               state_d       = S_HOLD;
            end
         end

         // Instruction is presented until the Control_unit advances.
         S_HOLD: begin
            if (pc_en_i) begin
               instr_valid_d = 1'b0;
               instr_d       = NOP_INSTR;
               pc_d          = next_pc_w;
`ifdef FETCH_MISALIGN_TRAP_EN
               if (misaligned_w) begin
                  fault_d = 1'b1;
                  req_d   = 1'b0;
                  state_d = S_FAULT;
               end else begin
                  req_d   = 1'b1;
                  state_d = S_REQ;
               end
`else
               req_d   = 1'b1;
               state_d = S_REQ;
`endif
            end
         end

         // Sticky trap: nothing but rst leaves this state.
         S_FAULT: begin
            req_d         = 1'b0;
            instr_d       = NOP_INSTR;
            instr_valid_d = 1'b0;
         end

         default: begin
            state_d = S_IDLE;
            req_d   = 1'b0;
         end
      endcase
   end

   assign imem_req_o    = req_q;
   assign imem_addr_o   = pc_q;
   assign instr_o       = instr_q;
   assign instr_valid_o = instr_valid_q;
   assign opcode_o      = instr_q[6:0];
   assign funct3_o      = instr_q[14:12];
   assign pc_o          = pc_q;
   assign pc_plus4_o    = pc_plus4_w;
   assign fetch_count_o = fetch_count_q;

endmodule
`default_nettype wire
